bram_boot_loader: RTL
=====================

// Module: bram_boot_loader
// PURPOSE
//  Boot-time sequencer for the AHB-lite block RAM. Receives a byte stream (e.g. from the UART RX),
//  packs it into 32-bit words, writes them into the BRAM, then releases the CPU. Holds the M0 in
//  reset while loading. Sits between the AHB BRAM bridge and the BRAM primitive; outside loading it
//  is a zero-latency pass-through.
// PARAMETERS
//  ADDR_WIDTH     11         BRAM word-address width; must match the bridge
//  TIMEOUT_W      24         width of the inter-byte timeout counter
//  TIMEOUT_CYC    5_000_000  max HCLK cycles between accepted bytes once a frame has started
//  BOOT_ON_RESET  1          1: leave reset in S_HDR (load); 0: leave reset in S_IDLE (run)
// PORTS
//  HCLK         in   1      clock
//  HRESETn      in   1      synchronous, active-low reset
//  boot_start   in   1      single-cycle pulse: start a new load
//  rx_valid     in   1      byte-stream valid
//  rx_data      in   8      byte-stream data
//  rx_ready     out  1      byte accepted when rx_valid & rx_ready
//  ahb_rdaddr   in   AW     bridge read address
//  ahb_wraddr   in   AW     bridge write address
//  ahb_wdata    in   32     bridge write data
//  ahb_write    in   4      bridge byte write strobes
//  BRAM_RDADDR  out  AW     to BRAM; always equals ahb_rdaddr
//  BRAM_WRADDR  out  AW     to BRAM
//  BRAM_WDATA   out  32     to BRAM
//  BRAM_WRITE   out  4      to BRAM byte strobes
//  cpu_hold     out  1      1 = keep CPU in reset
//  boot_done    out  1      sticky: last load succeeded
//  boot_err     out  1      sticky: last load failed
//  words_loaded out  AW+1   words written in the current or last load
// BEHAVIOUR
//  Frame: CNT_LO, CNT_HI (16-bit word count N, little-endian), 4*N data bytes (LE words), XOR_CHK
//  (XOR of all data bytes).
//  States: S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CHK, S_DONE, S_ERR.
//  - IDLE/DONE: cpu_hold=0, rx_ready=0, BRAM_* = ahb_* combinationally.
//    boot_start -> S_HDR0 (clears done/err/words_loaded/chk).
//  - HDR0/HDR1/DATA/CHK: cpu_hold=1, rx_ready=1, ahb_write ignored. BRAM_WRITE is 0 except during
//    loader writes.
//  - HDR1 exit: N > 2**ADDR_WIDTH -> S_ERR; N==0 -> S_CHK; else S_DATA.
//  - DATA: byte k of each word goes to lane k. On the 4th byte of a word, the following cycle drives
//    BRAM_WRITE=4'hF, BRAM_WRADDR=addr counter (starting at 0), BRAM_WDATA=packed word for exactly
//    1 cycle. The addr counter and words_loaded then increment. After word N -> S_CHK.
//  - CHK: received byte == running XOR -> S_DONE (boot_done=1), else S_ERR.
//  - ERR: boot_err=1, cpu_hold stays 1, rx_ready=0; wait for boot_start.
//  - boot_start in HDR0..CHK is ignored.
//  - Timeout: counter clears on each accepted byte and runs only after the first byte of a frame.
//    Reaching TIMEOUT_CYC -> S_ERR. A byte accepted in the same cycle as expiry wins.
//  - Reset: state = BOOT_ON_RESET ? S_HDR0 : S_IDLE; cpu_hold = BOOT_ON_RESET; rx_ready =
//    BOOT_ON_RESET; boot_done=0, boot_err=0, words_loaded=0. Internal write pulse is cleared, so a
//    reset mid-load discards the partial word. Already-written words are not erased.
//  - No back-pressure on the BRAM side: the write cycle never stalls rx_ready.
// STRUCTURE
//  - Shared package bram_boot_pkg: state encoding, header length (2), data bytes per word (4),
//    default TIMEOUT_CYC.
//  - One sub-module, bram_boot_word_packer: byte-lane shift/pack, lane counter, running XOR,
//    word_valid pulse. The top holds the FSM, address/word counters, timeout and output mux.
// TESTING
//  1 BOOT_ON_RESET=1, send 02 00 | 11 22 33 44 | 55 66 77 88 | chk=0x88
//    -> BRAM[0]=0x44332211, BRAM[1]=0x88776655, boot_done=1, cpu_hold=0, words_loaded=2.
//  2 Same frame with chk=0x00 -> boot_err=1, cpu_hold=1. Then boot_start + good frame ->
//    boot_done=1, boot_err=0.
//  3 N=0x0801 with ADDR_WIDTH=11 -> S_ERR right after CNT_HI, no BRAM write.
//    N=0, chk=0x00 -> boot_done.
//  4 Stop after 6 data bytes; after TIMEOUT_CYC idle cycles -> boot_err=1.
//    BRAM[0] is written, word 1 is not.
//  5 In S_DONE, ahb_write=4'h3, ahb_wraddr=5, ahb_wdata=0xAABB -> same-cycle BRAM pass-through.
//    During a load, ahb_write=4'hF -> BRAM_WRITE=0.
//  6 Assert HRESETn=0 for 1 cycle mid-word -> outputs at reset values; a full new frame loads
//    correctly from addr 0.

Source files
------------

// File: rtl/bram_boot_pkg.sv
// Shared definitions for the BRAM boot loader: loader states, frame geometry and default timeout.
package bram_boot_pkg;

    localparam int unsigned BYTE_W              = 8;
    localparam int unsigned WORD_W              = 32;
    localparam int unsigned BYTES_PER_WORD      = 4;
    localparam int unsigned LANE_W              = $clog2(BYTES_PER_WORD);
    localparam int unsigned HDR_BYTES           = 2;
    localparam int unsigned COUNT_W             = 16;
    localparam int unsigned DEFAULT_TIMEOUT_CYC = 5_000_000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } boot_state_e;

    // States in which the loader owns the byte stream and the BRAM write port.
    function automatic logic is_load_state(input boot_state_e s);
        return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) || (s == S_CHK);
    endfunction

    // States in which the CPU runs and the bridge talks to the BRAM directly.
    function automatic logic is_run_state(input boot_state_e s);
        return (s == S_IDLE) || (s == S_DONE);
    endfunction

endpackage

// File: rtl/bram_boot_word_packer.sv
// Packs little-endian bytes into 32-bit words, keeps the running XOR and pulses word_valid
// for one cycle after the fourth byte of each word.
module bram_boot_word_packer
    import bram_boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              last_lane_c,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic [BYTE_W-1:0] chk
);

    localparam int unsigned LOW_W = WORD_W - BYTE_W;

    logic [LANE_W-1:0] lane_q;
    logic [LOW_W-1:0]  low_q;

    assign last_lane_c = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

    // Earlier bytes shift down so byte k of a word ends up in lane k.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            lane_q     <= '0;
            low_q      <= '0;
            word_valid <= 1'b0;
            word       <= '0;
            chk        <= '0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                lane_q <= lane_q + LANE_W'(1);
                low_q  <= {byte_data, low_q[LOW_W-1:BYTE_W]};
                chk    <= chk ^ byte_data;
                if (last_lane_c) begin
                    word       <= {byte_data, low_q};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bram_boot_loader.sv
// Boot-time sequencer: loads a framed byte stream into the BRAM while holding the CPU in reset,
// otherwise passes the AHB bridge straight through to the BRAM.
module bram_boot_loader
    import bram_boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 11,
    parameter int unsigned TIMEOUT_W     = 24,
    parameter int unsigned TIMEOUT_CYC   = DEFAULT_TIMEOUT_CYC,
    parameter bit          BOOT_ON_RESET = 1'b1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  boot_start,
    input  logic                  rx_valid,
    input  logic [BYTE_W-1:0]     rx_data,
    output logic                  rx_ready,
    input  logic [ADDR_WIDTH-1:0] ahb_rdaddr,
    input  logic [ADDR_WIDTH-1:0] ahb_wraddr,
    input  logic [WORD_W-1:0]     ahb_wdata,
    input  logic [3:0]            ahb_write,
    output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
    output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
    output logic [WORD_W-1:0]     BRAM_WDATA,
    output logic [3:0]            BRAM_WRITE,
    output logic                  cpu_hold,
    output logic                  boot_done,
    output logic                  boot_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

    boot_state_e          state_q, state_d;
    logic                 ready_q, hold_q, done_q, err_q;
    logic [CNT_W-1:0]     words_q;
    logic [BYTE_W-1:0]    cnt_lo_q;
    logic [COUNT_W-1:0]   n_q;
    logic [COUNT_W-1:0]   n_c;
    logic [TIMEOUT_W-1:0] tmo_q;
    logic                 started_q;

    logic                 accept_c;
    logic                 clear_c;
    logic                 timeout_c;
    logic                 last_lane_c;
    logic                 word_valid;
    logic [WORD_W-1:0]    word;
    logic [BYTE_W-1:0]    chk;

    assign accept_c  = rx_valid & ready_q;
    assign n_c       = {rx_data, cnt_lo_q};
    assign timeout_c = started_q && !accept_c && (tmo_q == TIMEOUT_W'(TIMEOUT_CYC - 1));

    bram_boot_word_packer u_packer (
        .clk         (HCLK),
        .rst_n       (HRESETn),
        .clear       (clear_c),
        .byte_valid  (accept_c && (state_q == S_DATA)),
        .byte_data   (rx_data),
        .last_lane_c (last_lane_c),
        .word_valid  (word_valid),
        .word        (word),
        .chk         (chk)
    );

    // Frame sequencing; a byte arriving in the expiry cycle takes precedence over the timeout.
    always_comb begin
        state_d = state_q;
        clear_c = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (boot_start) begin
                    state_d = S_HDR0;
                    clear_c = 1'b1;
                end
            end
            S_HDR0: if (accept_c) state_d = S_HDR1;
            S_HDR1: begin
                if (accept_c) begin
                    if (32'(n_c) > DEPTH)   state_d = S_ERR;
                    else if (n_c == '0)     state_d = S_CHK;
                    else                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept_c && last_lane_c && (32'(words_q) + 32'd1 == 32'(n_q)))
                    state_d = S_CHK;
            end
            S_CHK: begin
                if (accept_c) state_d = (rx_data == chk) ? S_DONE : S_ERR;
            end
            default: state_d = S_ERR;
        endcase
        if (is_load_state(state_q) && timeout_c) state_d = S_ERR;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= BOOT_ON_RESET ? S_HDR0 : S_IDLE;
            hold_q    <= BOOT_ON_RESET;
            ready_q   <= BOOT_ON_RESET;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            words_q   <= '0;
            cnt_lo_q  <= '0;
            n_q       <= '0;
            tmo_q     <= '0;
            started_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= !is_run_state(state_d);
            ready_q <= is_load_state(state_d);
            if (state_q == S_HDR0 && accept_c) cnt_lo_q <= rx_data;
            if (state_q == S_HDR1 && accept_c) n_q <= n_c;
            if (clear_c) begin
                done_q    <= 1'b0;
                err_q     <= 1'b0;
                words_q   <= '0;
                tmo_q     <= '0;
                started_q <= 1'b0;
            end else begin
                if (state_q == S_CHK && state_d == S_DONE) done_q <= 1'b1;
                if (state_d == S_ERR) err_q <= 1'b1;
                if (word_valid) words_q <= words_q + CNT_W'(1);
                if (accept_c) begin
                    tmo_q     <= '0;
                    started_q <= 1'b1;
                end else if (started_q && is_load_state(state_q)) begin
                    tmo_q <= tmo_q + TIMEOUT_W'(1);
                end
            end
        end
    end

    // Loader write wins; the bridge reaches the BRAM only while the CPU is running.
    always_comb begin
        BRAM_WRADDR = ahb_wraddr;
        BRAM_WDATA  = ahb_wdata;
        BRAM_WRITE  = 4'h0;
        if (word_valid) begin
            BRAM_WRADDR = words_q[ADDR_WIDTH-1:0];
            BRAM_WDATA  = word;
            BRAM_WRITE  = 4'hF;
        end else if (is_run_state(state_q)) begin
            BRAM_WRITE  = ahb_write;
        end
    end

    assign BRAM_RDADDR  = ahb_rdaddr;
    assign rx_ready     = ready_q;
    assign cpu_hold     = hold_q;
    assign boot_done    = done_q;
    assign boot_err     = err_q;
    assign words_loaded = words_q;

endmodule
